lightbike_engine: RTL and testbench
===================================

Name: lightbike_engine

Overview:
- Parametrised game core for the lightbike design; replaces the fixed 16x16, two-player, one-hot game loop.
- Supports 2..4 players, configurable grid and move rate, round/match scoring and a clear-sweep grid init.
- Sits between the PS/2 decode logic (direction/start events) and the VGA renderer (cell read port, head positions).
- All logic runs on the single system clock; the move rate comes from an internal tick counter, not from a divided clock.

Parameters:
- GRID_W, 16, grid columns (>=8); column 0 and GRID_W-1 are walls.
- GRID_H, 16, grid rows (>=8); row 0 and GRID_H-1 are walls.
- NUM_PLAYERS, 2, player count, 2..4.
- TICK_DIV, 4, clk cycles per move tick (>=2).
- WIN_SCORE, 3, round wins needed to win the match (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse; acknowledge/advance
- dir_valid  in  1  direction event strobe
- dir_player  in  2  player index of the event
- dir_code  in  2  UP=0 RIGHT=1 DOWN=2 LEFT=3
- rd_x  in  log2(GRID_W)  renderer read column
- rd_y  in  log2(GRID_H)  renderer read row
- rd_cell  out  1  occupancy of (rd_x,rd_y); 1-cycle latency; walls read 1
- head_x  out  NUM_PLAYERS*log2(GRID_W)  packed head columns
- head_y  out  NUM_PLAYERS*log2(GRID_H)  packed head rows
- alive  out  NUM_PLAYERS  alive mask
- state  out  3  encoded FSM state
- scores  out  NUM_PLAYERS*4  packed round-win counts
- winner  out  3  last round winner index; 7 = draw

Behaviour:
Reset:
- state=CLEAR; scores=0; winner=7; alive=0; rd_cell=0; tick counter=0.
- reset mid-round aborts the round and clears the scores.

FSM states: CLEAR, WAIT_START, DRIVING, ROUND_OVER, GAME_OVER.
- CLEAR: zeroes one grid row per cycle, rows 0..GRID_H-1 (GRID_H cycles), then loads the start positions and goes to WAIT_START.
  - Player i starts at x=(i+1)*GRID_W/(NUM_PLAYERS+1), y=GRID_H/2.
  - Even i starts RIGHT, odd i starts LEFT.
  - alive = all ones.
- WAIT_START: start -> DRIVING; tick counter = 0.
- DRIVING: tick counter counts 0..TICK_DIV-1. At terminal count (a tick):
  - commit the pending directions;
  - compute each alive player's next cell;
  - mark all alive heads' current cells occupied;
  - a player crashes if its next cell is a wall, is occupied, equals any alive head's current cell, or equals another alive player's next cell;
  - crashed players clear their alive bit and do not move;
  - survivors move.
  - Round end: if the alive count after the tick is <=1, go to ROUND_OVER.
    - A sole survivor gets winner=index and its score +1 (saturating at 15).
    - No survivors gives winner=7 and no score change.
- ROUND_OVER: start -> GAME_OVER if any score == WIN_SCORE, else CLEAR (scores kept).
- GAME_OVER: start -> CLEAR with scores zeroed and winner=7.
- start is ignored in CLEAR and DRIVING.

Direction handling:
- dir_valid accepted in any state.
- dir_player >= NUM_PLAYERS is ignored.
- A code that reverses the committed direction (XOR == 2) is ignored.
- Otherwise it overwrites the pending direction; the last accepted event before a tick wins.
- An event arriving in the tick cycle applies to the next tick.

Read port:
- rd_cell registered from the grid, or 1 for a wall coordinate.
- Out-of-range coordinates return 0.
- Writes in the same cycle are not visible until the next cycle.

Widths:
- Coordinates are unsigned; the next-cell computation uses one extra bit so that 0-1 is detected as a wall, not a wrap.

Decomposition:
- Package lightbike_pkg: direction codes, FSM state encodings, DRAW=3'd7, function clog2, function next_xy(x,y,dir).
- Sub-module lightbike_grid: GRID_H x GRID_W bit array with a row-clear port, up to NUM_PLAYERS set ports and one registered read port.

Test Plan (16x16, 2 players, TICK_DIV=4):
1. Reset, then 16 cycles -> state=WAIT_START, heads P0(5,8) P1(10,8), alive=2'b11, rd_cell(0,3)=1, rd_cell(7,7)=0.
2. start, no input -> P0 x=6/7 and P1 x=9/8 after ticks 1/2; tick 3 both crash -> ROUND_OVER, winner=7, scores=0.
3. After start: P0 dir UP, P1 dir DOWN -> tick 7 P1 hits row 15, P0 at (5,1) -> winner=0, score0=1.
4. In DRIVING with P0 RIGHT: send LEFT -> ignored; then UP and DOWN in one tick window -> DOWN taken, P0 y+1 at the tick.
5. Repeat scenario 3 with WIN_SCORE=3 for three rounds -> after the third ROUND_OVER start -> GAME_OVER; next start -> CLEAR, scores=0.
6. Assert reset for one cycle mid-DRIVING -> next cycle state=CLEAR, scores=0, alive=0, winner=7.

Source files
------------

// File: rtl/lightbike_pkg.sv
// Shared types and helpers for the lightbike game core: direction codes,
// FSM encodings, the draw marker and the next-cell computation.
package lightbike_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      ST_CLEAR      = 3'd0,
      ST_WAIT_START = 3'd1,
      ST_DRIVING    = 3'd2,
      ST_ROUND_OVER = 3'd3,
      ST_GAME_OVER  = 3'd4
   } state_t;

   localparam logic [2:0] DRAW = 3'd7;

   // Extended coordinate width: one spare bit so that 0-1 lands far outside the grid
   localparam int CW = 9;
   typedef logic [CW-1:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } xy_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic xy_t next_xy(input coord_t x, input coord_t y, input dir_t d);
      xy_t r;
      r.x = x;
      r.y = y;
      case (d)
         DIR_UP:    r.y = y - coord_t'(1'b1);
         DIR_RIGHT: r.x = x + coord_t'(1'b1);
         DIR_DOWN:  r.y = y + coord_t'(1'b1);
         DIR_LEFT:  r.x = x - coord_t'(1'b1);
         default:   r.x = x;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lightbike_grid.sv
// Occupancy bit array: one row cleared per cycle, per-player set ports,
// combinational occupancy lookups for collision checks and a registered read port.
module lightbike_grid
   import lightbike_pkg::*;
#(
   parameter int GRID_W      = 16,
   parameter int GRID_H      = 16,
   parameter int NUM_PLAYERS = 2,
   localparam int XW = clog2(GRID_W),
   localparam int YW = clog2(GRID_H)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr_en,
   input  logic [YW-1:0]             clr_row,
   input  logic [NUM_PLAYERS-1:0]    set_en,
   input  logic [NUM_PLAYERS*XW-1:0] set_x,
   input  logic [NUM_PLAYERS*YW-1:0] set_y,
   input  logic [NUM_PLAYERS*CW-1:0] q_x,
   input  logic [NUM_PLAYERS*CW-1:0] q_y,
   output logic [NUM_PLAYERS-1:0]    q_occ,
   input  logic [XW-1:0]             rd_x,
   input  logic [YW-1:0]             rd_y,
   output logic                      rd_cell
);

   logic [GRID_W-1:0] cells_r [GRID_H];

   // row clear sweep and head marking
   always_ff @(posedge clk) begin
      if (clr_en) begin
         cells_r[clr_row] <= '0;
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (set_en[i]) cells_r[set_y[i*YW +: YW]][set_x[i*XW +: XW]] <= 1'b1;
         end
      end
   end

   // occupancy lookup of candidate next cells; off-grid cells are handled as walls by the caller
   always_comb begin
      q_occ = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if ((q_x[i*CW +: CW] < coord_t'(GRID_W)) && (q_y[i*CW +: CW] < coord_t'(GRID_H)))
            q_occ[i] = cells_r[q_y[i*CW +: YW]][q_x[i*XW - i*XW + i*CW +: XW]];
         else
            q_occ[i] = 1'b0;
      end
   end

   // registered renderer read; wall coordinates override the array
   always_ff @(posedge clk) begin
      if (reset)
         rd_cell <= 1'b0;
      else if ((int'(rd_x) >= GRID_W) || (int'(rd_y) >= GRID_H))
         rd_cell <= 1'b0;
      else if ((rd_x == '0) || (rd_y == '0) || (int'(rd_x) == GRID_W-1) || (int'(rd_y) == GRID_H-1))
         rd_cell <= 1'b1;
      else
         rd_cell <= cells_r[rd_y][rd_x];
   end

endmodule

// File: rtl/lightbike_engine.sv
// Lightbike game core: clear sweep, tick-paced movement of 2..4 players,
// collision resolution, round/match scoring and direction-event filtering.
module lightbike_engine
   import lightbike_pkg::*;
#(
   parameter int GRID_W      = 16,
   parameter int GRID_H      = 16,
   parameter int NUM_PLAYERS = 2,
   parameter int TICK_DIV    = 4,
   parameter int WIN_SCORE   = 3,
   localparam int XW = clog2(GRID_W),
   localparam int YW = clog2(GRID_H)
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      dir_valid,
   input  logic [1:0]                dir_player,
   input  logic [1:0]                dir_code,
   input  logic [XW-1:0]             rd_x,
   input  logic [YW-1:0]             rd_y,
   output logic                      rd_cell,
   output logic [NUM_PLAYERS*XW-1:0] head_x,
   output logic [NUM_PLAYERS*YW-1:0] head_y,
   output logic [NUM_PLAYERS-1:0]    alive,
   output logic [2:0]                state,
   output logic [NUM_PLAYERS*4-1:0]  scores,
   output logic [2:0]                winner
);

   localparam int TW = clog2(TICK_DIV);

   state_t                   state_r, state_s;
   logic [TW-1:0]            tick_r;
   logic [YW-1:0]            row_r;
   logic [XW-1:0]            hx_r [NUM_PLAYERS];
   logic [YW-1:0]            hy_r [NUM_PLAYERS];
   dir_t                     dir_r [NUM_PLAYERS];
   dir_t                     pend_r [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]   alive_r;
   logic [3:0]               score_r [NUM_PLAYERS];
   logic [2:0]               winner_r;

   logic                      tick_s, round_end_s, match_won_s;
   xy_t                       nxt_s [NUM_PLAYERS];
   logic [NUM_PLAYERS-1:0]    crash_s, alive_nx_s, occ_s, set_en_s;
   logic [2:0]                live_cnt_s, survivor_s;
   logic [NUM_PLAYERS*CW-1:0] q_x_s, q_y_s;
   logic [NUM_PLAYERS*XW-1:0] set_x_s;
   logic [NUM_PLAYERS*YW-1:0] set_y_s;

   assign tick_s = (state_r == ST_DRIVING) && (tick_r == TW'(TICK_DIV-1));

   // collision resolution for the coming tick; the grid is read before this tick's heads are marked,
   // so current heads are compared explicitly
   always_comb begin
      crash_s     = '0;
      alive_nx_s  = '0;
      live_cnt_s  = 3'd0;
      survivor_s  = DRAW;
      match_won_s = 1'b0;
      q_x_s       = '0;
      q_y_s       = '0;
      set_x_s     = '0;
      set_y_s     = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         nxt_s[i] = next_xy(coord_t'(hx_r[i]), coord_t'(hy_r[i]), pend_r[i]);
         q_x_s[i*CW +: CW]   = nxt_s[i].x;
         q_y_s[i*CW +: CW]   = nxt_s[i].y;
         set_x_s[i*XW +: XW] = hx_r[i];
         set_y_s[i*YW +: YW] = hy_r[i];
         match_won_s = match_won_s | (score_r[i] == 4'(WIN_SCORE));
      end
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         crash_s[i] = (nxt_s[i].x == '0) || (nxt_s[i].x >= coord_t'(GRID_W-1)) ||
                      (nxt_s[i].y == '0) || (nxt_s[i].y >= coord_t'(GRID_H-1)) || occ_s[i];
         for (int j = 0; j < NUM_PLAYERS; j++) begin
            crash_s[i] = crash_s[i] | (alive_r[j] && (nxt_s[i].x == coord_t'(hx_r[j])) &&
                                       (nxt_s[i].y == coord_t'(hy_r[j])));
            crash_s[i] = crash_s[i] | (alive_r[j] && (j != i) && (nxt_s[i] == nxt_s[j]));
         end
         alive_nx_s[i] = alive_r[i] & ~crash_s[i];
         live_cnt_s    = live_cnt_s + {2'b00, alive_nx_s[i]};
         survivor_s    = alive_nx_s[i] ? 3'(i) : survivor_s;
      end
      round_end_s = (live_cnt_s <= 3'd1);
   end

   assign set_en_s = tick_s ? alive_r : '0;

   lightbike_grid #(
      .GRID_W      (GRID_W),
      .GRID_H      (GRID_H),
      .NUM_PLAYERS (NUM_PLAYERS)
   ) u_grid (
      .clk     (clk),
      .reset   (reset),
      .clr_en  (state_r == ST_CLEAR),
      .clr_row (row_r),
      .set_en  (set_en_s),
      .set_x   (set_x_s),
      .set_y   (set_y_s),
      .q_x     (q_x_s),
      .q_y     (q_y_s),
      .q_occ   (occ_s),
      .rd_x    (rd_x),
      .rd_y    (rd_y),
      .rd_cell (rd_cell)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_CLEAR;
      else       state_r <= state_s;
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_CLEAR:      if (int'(row_r) == GRID_H-1) state_s = ST_WAIT_START; else state_s = ST_CLEAR;
         ST_WAIT_START: if (start) state_s = ST_DRIVING; else state_s = ST_WAIT_START;
         ST_DRIVING:    if (tick_s && round_end_s) state_s = ST_ROUND_OVER; else state_s = ST_DRIVING;
         ST_ROUND_OVER: begin
            if (start) state_s = match_won_s ? ST_GAME_OVER : ST_CLEAR;
            else       state_s = ST_ROUND_OVER;
         end
         ST_GAME_OVER:  if (start) state_s = ST_CLEAR; else state_s = ST_GAME_OVER;
         default:       state_s = ST_CLEAR;
      endcase
   end

   // game datapath: direction filtering, clear sweep, movement and scoring
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_r   <= '0;
         row_r    <= '0;
         alive_r  <= '0;
         winner_r <= DRAW;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            hx_r[i]    <= '0;
            hy_r[i]    <= '0;
            dir_r[i]   <= DIR_UP;
            pend_r[i]  <= DIR_UP;
            score_r[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (dir_valid && (dir_player == 2'(i)) && ((dir_code ^ dir_r[i]) != 2'd2))
               pend_r[i] <= dir_t'(dir_code);
         end
         case (state_r)
            ST_CLEAR: begin
               row_r <= row_r + YW'(1'b1);
               if (int'(row_r) == GRID_H-1) begin
                  row_r   <= '0;
                  alive_r <= '1;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     hx_r[i]   <= XW'((i + 1) * GRID_W / (NUM_PLAYERS + 1));
                     hy_r[i]   <= YW'(GRID_H / 2);
                     dir_r[i]  <= (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
                     pend_r[i] <= (i % 2 == 0) ? DIR_RIGHT : DIR_LEFT;
                  end
               end
            end
            ST_WAIT_START: begin
               if (start) tick_r <= '0;
            end
            ST_DRIVING: begin
               tick_r <= tick_s ? '0 : tick_r + TW'(1'b1);
               if (tick_s) begin
                  alive_r <= alive_nx_s;
                  for (int i = 0; i < NUM_PLAYERS; i++) begin
                     dir_r[i] <= pend_r[i];
                     if (alive_nx_s[i]) begin
                        hx_r[i] <= nxt_s[i].x[XW-1:0];
                        hy_r[i] <= nxt_s[i].y[YW-1:0];
                     end
                     if (round_end_s && alive_nx_s[i] && (score_r[i] != 4'hF))
                        score_r[i] <= score_r[i] + 4'd1;
                  end
                  if (round_end_s) winner_r <= (live_cnt_s == 3'd1) ? survivor_s : DRAW;
               end
            end
            ST_ROUND_OVER: begin
               if (start) begin
                  row_r   <= '0;
                  alive_r <= '0;
               end
            end
            ST_GAME_OVER: begin
               if (start) begin
                  row_r    <= '0;
                  alive_r  <= '0;
                  winner_r <= DRAW;
                  for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= 4'd0;
               end
            end
            default: row_r <= '0;
         endcase
      end
   end

   // pack per-player registers onto the output buses
   always_comb begin
      head_x = '0;
      head_y = '0;
      scores = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         head_x[i*XW +: XW] = hx_r[i];
         head_y[i*YW +: YW] = hy_r[i];
         scores[i*4 +: 4]   = score_r[i];
      end
   end

   assign alive  = alive_r;
   assign state  = state_r;
   assign winner = winner_r;

endmodule

// File: tb/tb_lightbike_engine.sv
// Self-checking bench for lightbike_engine: read-port vector table, directed
// round scenarios, and randomized rounds against a tick-level game model.
module tb_lightbike_engine;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int NP = 2;
   localparam int WS = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       dir_valid = 1'b0;
   logic [1:0] dir_player = 2'd0;
   logic [1:0] dir_code = 2'd0;
   logic [3:0] rd_x = 4'd0;
   logic [3:0] rd_y = 4'd0;
   logic       rd_cell;
   logic [7:0] head_x, head_y, scores;
   logic [1:0] alive;
   logic [2:0] state, winner;

   int checks = 0;
   int failures = 0;

   lightbike_engine #(
      .GRID_W(W), .GRID_H(H), .NUM_PLAYERS(NP), .TICK_DIV(4), .WIN_SCORE(WS)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .dir_valid(dir_valid),
      .dir_player(dir_player), .dir_code(dir_code), .rd_x(rd_x), .rd_y(rd_y),
      .rd_cell(rd_cell), .head_x(head_x), .head_y(head_y), .alive(alive),
      .state(state), .scores(scores), .winner(winner)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: run did not finish, actual=hang required=finish");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input int p, input int c);
      dir_valid  = 1'b1;
      dir_player = 2'(p);
      dir_code   = 2'(c);
      step();
      dir_valid  = 1'b0;
   endtask

   function automatic int hx(input int i); return int'(head_x[i*4 +: 4]); endfunction
   function automatic int hy(input int i); return int'(head_y[i*4 +: 4]); endfunction
   function automatic int sc(input int i); return int'(scores[i*4 +: 4]); endfunction

   // tick-level game model
   bit mgrid [H][W];
   int mx [NP], my [NP], mdir [NP], mpend [NP], mscore [NP];
   bit malive [NP];
   int mwin = 7;

   function automatic bit mwall(input int x, input int y);
      return (x <= 0) || (y <= 0) || (x >= W-1) || (y >= H-1);
   endfunction

   task automatic m_round_init();
      for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) mgrid[y][x] = 1'b0;
      for (int i = 0; i < NP; i++) begin
         mx[i] = (i + 1) * W / (NP + 1);
         my[i] = H / 2;
         mdir[i] = (i % 2 == 0) ? 1 : 3;
         mpend[i] = mdir[i];
         malive[i] = 1'b1;
      end
   endtask

   task automatic m_event(input int p, input int c);
      if (p < NP && ((c ^ mdir[p]) != 2)) mpend[p] = c;
   endtask

   task automatic m_tick(output bit over);
      int nx [NP];
      int ny [NP];
      bit cr [NP];
      int cnt, idx;
      for (int i = 0; i < NP; i++) begin
         mdir[i] = mpend[i];
         nx[i] = mx[i] + (mdir[i] == 1 ? 1 : 0) - (mdir[i] == 3 ? 1 : 0);
         ny[i] = my[i] + (mdir[i] == 2 ? 1 : 0) - (mdir[i] == 0 ? 1 : 0);
      end
      for (int i = 0; i < NP; i++) begin
         cr[i] = 1'b0;
         if (mwall(nx[i], ny[i])) cr[i] = 1'b1;
         else if (mgrid[ny[i]][nx[i]]) cr[i] = 1'b1;
         for (int j = 0; j < NP; j++) begin
            if (malive[j] && nx[i] == mx[j] && ny[i] == my[j]) cr[i] = 1'b1;
            if (malive[j] && j != i && nx[i] == nx[j] && ny[i] == ny[j]) cr[i] = 1'b1;
         end
      end
      for (int i = 0; i < NP; i++) if (malive[i]) mgrid[my[i]][mx[i]] = 1'b1;
      cnt = 0;
      idx = 7;
      for (int i = 0; i < NP; i++) begin
         if (malive[i] && cr[i]) malive[i] = 1'b0;
         else if (malive[i]) begin
            mx[i] = nx[i];
            my[i] = ny[i];
            cnt++;
            idx = i;
         end
      end
      over = (cnt <= 1);
      if (over) begin
         mwin = (cnt == 1) ? idx : 7;
         if (cnt == 1 && mscore[idx] < 15) mscore[idx]++;
      end
   endtask

   task automatic rand_round(input int r);
      bit over;
      int t, p, c, x, y, expc;
      m_round_init();
      repeat ($urandom_range(0, 3)) begin
         p = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         m_event(p, c);
         send(p, c);
      end
      pulse_start();
      over = 1'b0;
      t = 0;
      while (!over && t < 300) begin
         for (int s = 0; s < 3; s++) begin
            if ($urandom_range(0, 2) == 0) begin
               p = $urandom_range(0, 3);
               c = $urandom_range(0, 3);
               m_event(p, c);
               send(p, c);
            end else begin
               step();
            end
         end
         step();
         m_tick(over);
         t++;
         for (int i = 0; i < NP; i++) begin
            chk($sformatf("rnd%0d_t%0d_hx%0d", r, t, i), hx(i), mx[i]);
            chk($sformatf("rnd%0d_t%0d_hy%0d", r, t, i), hy(i), my[i]);
            chk($sformatf("rnd%0d_t%0d_alive%0d", r, t, i), int'(alive[i]), int'(malive[i]));
         end
         chk($sformatf("rnd%0d_t%0d_state", r, t), int'(state), over ? 3 : 2);
      end
      if (!over) chk($sformatf("rnd%0d_tick_bound", r), 0, 1);
      chk($sformatf("rnd%0d_winner", r), int'(winner), mwin);
      for (int i = 0; i < NP; i++) chk($sformatf("rnd%0d_score%0d", r, i), sc(i), mscore[i]);
      repeat (8) begin
         x = $urandom_range(0, W-1);
         y = $urandom_range(0, H-1);
         rd_x = 4'(x);
         rd_y = 4'(y);
         step();
         expc = mwall(x, y) ? 1 : int'(mgrid[y][x]);
         chk($sformatf("rnd%0d_rd(%0d,%0d)", r, x, y), int'(rd_cell), expc);
      end
      pulse_start();
      if (mscore[0] == WS || mscore[1] == WS) begin
         chk($sformatf("rnd%0d_game_over", r), int'(state), 4);
         pulse_start();
         for (int i = 0; i < NP; i++) mscore[i] = 0;
         mwin = 7;
         chk($sformatf("rnd%0d_match_scores", r), int'(scores), 0);
         chk($sformatf("rnd%0d_match_winner", r), int'(winner), 7);
      end
      chk($sformatf("rnd%0d_clear", r), int'(state), 0);
      step(16);
      chk($sformatf("rnd%0d_wait", r), int'(state), 1);
   endtask

   typedef struct {
      int x;
      int y;
      int exp;
   } rd_vec_t;

   rd_vec_t rtab [10];

   initial begin
      rtab[0] = '{0, 3, 1};   rtab[1] = '{7, 7, 0};   rtab[2] = '{15, 0, 1};
      rtab[3] = '{8, 15, 1};  rtab[4] = '{1, 1, 0};   rtab[5] = '{14, 14, 0};
      rtab[6] = '{5, 8, 0};   rtab[7] = '{15, 15, 1}; rtab[8] = '{10, 8, 0};
      rtab[9] = '{14, 1, 0};

      // reset and clear sweep
      step();
      reset = 1'b0;
      chk("reset_state", int'(state), 0);
      chk("reset_scores", int'(scores), 0);
      chk("reset_winner", int'(winner), 7);
      chk("reset_alive", int'(alive), 0);
      chk("reset_rd_cell", int'(rd_cell), 0);
      step(15);
      chk("clear_not_done", int'(state), 0);
      step();
      chk("wait_state", int'(state), 1);
      chk("p0_start_x", hx(0), 5);
      chk("p0_start_y", hy(0), 8);
      chk("p1_start_x", hx(1), 10);
      chk("p1_start_y", hy(1), 8);
      chk("start_alive", int'(alive), 3);

      for (int i = 0; i < 10; i++) begin
         rd_x = 4'(rtab[i].x);
         rd_y = 4'(rtab[i].y);
         step();
         chk($sformatf("rd_tab%0d(%0d,%0d)", i, rtab[i].x, rtab[i].y), int'(rd_cell), rtab[i].exp);
      end

      // head-on draw with no input
      pulse_start();
      chk("drive_state", int'(state), 2);
      step(3);
      chk("no_move_before_tick", hx(0), 5);
      step();
      chk("t1_p0_x", hx(0), 6);
      chk("t1_p1_x", hx(1), 9);
      step(4);
      chk("t2_p0_x", hx(0), 7);
      chk("t2_p1_x", hx(1), 8);
      chk("t2_state", int'(state), 2);
      step(4);
      chk("draw_state", int'(state), 3);
      chk("draw_winner", int'(winner), 7);
      chk("draw_scores", int'(scores), 0);
      chk("draw_alive", int'(alive), 0);
      chk("draw_p0_stays", hx(0), 7);
      rd_x = 4'd7; rd_y = 4'd8;
      step();
      chk("draw_trail_cell", int'(rd_cell), 1);

      // P0 up, P1 down: P1 hits the bottom wall on tick 7
      pulse_start();
      chk("ro_to_clear", int'(state), 0);
      step(16);
      chk("wait2", int'(state), 1);
      send(0, 0);
      send(1, 2);
      pulse_start();
      step(24);
      chk("s3_t6_state", int'(state), 2);
      chk("s3_t6_p1_y", hy(1), 14);
      chk("s3_t6_p0_y", hy(0), 2);
      step(4);
      chk("s3_state", int'(state), 3);
      chk("s3_winner", int'(winner), 0);
      chk("s3_score0", sc(0), 1);
      chk("s3_score1", sc(1), 0);
      chk("s3_p0_x", hx(0), 5);
      chk("s3_p0_y", hy(0), 1);
      chk("s3_alive", int'(alive), 1);

      // reversal ignored, last accepted event in the window wins
      pulse_start();
      step(16);
      pulse_start();
      send(0, 3);
      send(0, 0);
      send(0, 2);
      step();
      chk("s4_p0_x", hx(0), 5);
      chk("s4_p0_y", hy(0), 9);
      chk("s4_p1_x", hx(1), 9);
      step(16);
      chk("s4_state", int'(state), 3);
      chk("s4_winner", int'(winner), 0);
      chk("s4_score0", sc(0), 2);
      chk("s4_p0_y", hy(0), 13);
      chk("s4_p1_x", hx(1), 6);
      chk("s4_alive", int'(alive), 1);

      // reset mid-round
      pulse_start();
      step(16);
      pulse_start();
      step(6);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_reset_state", int'(state), 0);
      chk("mid_reset_scores", int'(scores), 0);
      chk("mid_reset_alive", int'(alive), 0);
      chk("mid_reset_winner", int'(winner), 7);
      step(16);
      chk("mid_reset_wait", int'(state), 1);

      // three wins for P0 reach the match end
      for (int r = 0; r < 3; r++) begin
         send(0, 0);
         send(1, 2);
         pulse_start();
         step(28);
         chk($sformatf("m%0d_state", r), int'(state), 3);
         chk($sformatf("m%0d_score0", r), sc(0), r + 1);
         pulse_start();
         if (r < 2) begin
            chk($sformatf("m%0d_clear", r), int'(state), 0);
            step(16);
         end
      end
      chk("game_over_state", int'(state), 4);
      chk("game_over_score0", sc(0), 3);
      pulse_start();
      chk("go_clear_state", int'(state), 0);
      chk("go_clear_scores", int'(scores), 0);
      chk("go_clear_winner", int'(winner), 7);
      step(16);
      chk("go_wait", int'(state), 1);

      // randomized rounds against the model
      for (int i = 0; i < NP; i++) mscore[i] = 0;
      mwin = 7;
      for (int r = 0; r < 10; r++) rand_round(r);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
